// File: rtl/batch_pkg.sv
// batch_pkg: shared slot-state type and default sizing for the multi-bank
// batch controller (batch_ctrl_pp) and its drain sub-block.
package batch_pkg;

   // Life cycle of one sample slot.
   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      FILLED    = 2'd1,
      COMPUTING = 2'd2,
      DONE      = 2'd3
   } slot_state_e;

   localparam int DEF_AW    = 12;
   localparam int DEF_NBANK = 2;

endpackage

// File: rtl/stream_drain.sv
// stream_drain: walks the dst buffer of the slot being drained, issuing one
// read per accepted output beat.  dst_buf has one cycle of read latency and
// holds its output while dst_v is low, so the valid/last registers here line
// up with the buffer data and simply hold under backpressure.
module stream_drain
   import batch_pkg::*;
#(
   parameter int AW = DEF_AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          slot_done_i,
   input  logic [AW-1:0] ds_i,
   input  logic          dst_ready_i,
   output logic          dst_v_o,
   output logic [AW-1:0] dst_a_o,
   output logic          dst_valid_o,
   output logic          dst_last_o,
   output logic          drained_o
);

   logic [AW-1:0] cnt_q, cnt_d;
   logic          issued_q, issued_d;   // every word of this slot has been read
   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic          issue;

   // A new read may only be issued when the output register is free or
   // emptying this cycle; otherwise the buffer output must stay frozen.
   assign issue     = slot_done_i & ~issued_q & (~valid_q | dst_ready_i);
   assign drained_o = valid_q & dst_ready_i & last_q;

   assign dst_v_o     = issue;
   assign dst_a_o     = cnt_q;
   assign dst_valid_o = valid_q;
   assign dst_last_o  = last_q;

   // Next-state for read address, issue-complete flag and output beat flags.
   always_comb begin
      cnt_d    = cnt_q;
      issued_d = issued_q;
      valid_d  = valid_q;
      last_d   = last_q;
      if (drained_o) begin
         issued_d = 1'b0;
      end
      if (issue) begin
         last_d = (cnt_q == ds_i);
         if (cnt_q == ds_i) begin
            cnt_d    = '0;
            issued_d = 1'b1;
         end else begin
            cnt_d = cnt_q + AW'(1);
         end
      end
      if (issue) begin
         valid_d = 1'b1;
      end else if (dst_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Drain pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         issued_q <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         issued_q <= issued_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
      end
   end

endmodule

// File: rtl/batch_ctrl_pp.sv
// batch_ctrl_pp: multi-bank sequencer between the input stream, the src/dst
// sample buffers and the sample controller.  Slots move
// EMPTY -> FILLED -> COMPUTING -> DONE -> EMPTY; fill, compute and drain each
// own a pointer that walks the ring in order, so different slots can be in
// different phases at once.
// Optional build macro BATCH_CTRL_PP_CHECK_EN enables the sticky err flags;
// without it err is tied low and src_last is ignored.
module batch_ctrl_pp
   import batch_pkg::*;
#(
   parameter  int AW    = DEF_AW,
   parameter  int NBANK = DEF_NBANK,
   localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          src_valid,
   input  logic          src_last,
   output logic          src_ready,
   output logic          src_v,
   output logic [AW-1:0] src_a,
   output logic [BW-1:0] src_b,
   input  logic [AW-1:0] ss,
   input  logic [AW-1:0] ds,
   output logic          s_init,
   output logic [BW-1:0] s_bank,
   input  logic          s_fin,
   output logic          dst_v,
   output logic [AW-1:0] dst_a,
   output logic [BW-1:0] dst_b,
   output logic          dst_valid,
   output logic          dst_last,
   input  logic          dst_ready,
   output logic          busy,
   output logic [1:0]    err
);

   slot_state_e   slot_q [NBANK];
   slot_state_e   slot_d [NBANK];
   logic [BW-1:0] fill_p_q, fill_p_d;
   logic [BW-1:0] comp_p_q, comp_p_d;
   logic [BW-1:0] drain_p_q, drain_p_d;
   logic [AW-1:0] fill_cnt_q, fill_cnt_d;

   slot_state_e   fill_cur, comp_cur, drain_cur;
   logic          fill_end, fin_ok, drained;

   function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
      if (int'(p) == NBANK - 1) begin
         return '0;
      end
      return p + BW'(1);
   endfunction

   assign fill_cur  = slot_q[fill_p_q];
   assign comp_cur  = slot_q[comp_p_q];
   assign drain_cur = slot_q[drain_p_q];

   assign src_ready = run & (fill_cur == EMPTY);
   assign src_v     = src_valid & src_ready;
   assign src_a     = fill_cnt_q;
   assign src_b     = fill_p_q;
   assign fill_end  = src_v & (fill_cnt_q == ss);

   // Only one compute runs at a time and comp_p sits on it, so a FILLED slot
   // under comp_p also means the sample controller is idle.
   assign s_init = run & (comp_cur == FILLED);
   assign s_bank = comp_p_q;
   assign fin_ok = s_fin & (comp_cur == COMPUTING);

   assign dst_b = drain_p_q;

   stream_drain #(
      .AW (AW)
   ) u_drain (
      .clk         (clk),
      .reset       (reset),
      .slot_done_i (drain_cur == DONE),
      .ds_i        (ds),
      .dst_ready_i (dst_ready),
      .dst_v_o     (dst_v),
      .dst_a_o     (dst_a),
      .dst_valid_o (dst_valid),
      .dst_last_o  (dst_last),
      .drained_o   (drained)
   );

   // Slot transitions; the three phases act on distinct slots and all apply.
   always_comb begin
      slot_d     = slot_q;
      fill_p_d   = fill_p_q;
      comp_p_d   = comp_p_q;
      drain_p_d  = drain_p_q;
      fill_cnt_d = fill_cnt_q;
      if (src_v) begin
         if (fill_end) begin
            fill_cnt_d       = '0;
            slot_d[fill_p_q] = FILLED;
            fill_p_d         = ptr_inc(fill_p_q);
         end else begin
            fill_cnt_d = fill_cnt_q + AW'(1);
         end
      end
      if (s_init) begin
         slot_d[comp_p_q] = COMPUTING;
      end
      if (fin_ok) begin
         slot_d[comp_p_q] = DONE;
         comp_p_d         = ptr_inc(comp_p_q);
      end
      if (drained) begin
         slot_d[drain_p_q] = EMPTY;
         drain_p_d         = ptr_inc(drain_p_q);
      end
   end

   // Slot ring and pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NBANK; i++) begin
            slot_q[i] <= EMPTY;
         end
         fill_p_q   <= '0;
         comp_p_q   <= '0;
         drain_p_q  <= '0;
         fill_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NBANK; i++) begin
            slot_q[i] <= slot_d[i];
         end
         fill_p_q   <= fill_p_d;
         comp_p_q   <= comp_p_d;
         drain_p_q  <= drain_p_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   // Busy while any slot holds a sample (a partial fill still counts as EMPTY).
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NBANK; i++) begin
         if (slot_q[i] != EMPTY) begin
            busy = 1'b1;
         end
      end
   end

`ifdef BATCH_CTRL_PP_CHECK_EN
   logic [1:0] err_q, err_d;

   // Sticky protocol flags: framing mismatch and orphan s_fin.
   always_comb begin
      err_d = err_q;
      if (src_v && (src_last != (fill_cnt_q == ss))) begin
         err_d[0] = 1'b1;
      end
      if (s_fin && (comp_cur != COMPUTING)) begin
         err_d[1] = 1'b1;
      end
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_src_last;
   assign unused_src_last = src_last;
   assign err = 2'b00;
`endif

endmodule

// File: tb/tb_batch_ctrl_pp.sv
// tb_batch_ctrl_pp: directed table, hand-written corner sequences and a
// randomized run against a counter-level model of the slot ring.
module tb_batch_ctrl_pp;

   localparam int AW    = 12;
   localparam int NBANK = 2;
   localparam int BW    = 1;

   logic          clk = 1'b0;
   logic          reset, run, src_valid, src_last, s_fin, dst_ready;
   logic [AW-1:0] ss, ds;
   logic          src_ready, src_v, s_init, dst_v, dst_valid, dst_last, busy;
   logic [AW-1:0] src_a, dst_a;
   logic [BW-1:0] src_b, s_bank, dst_b;
   logic [1:0]    err;

   int vectors = 0;
   int miscompares = 0;

`ifdef BATCH_CTRL_PP_CHECK_EN
   localparam logic [1:0] ERR01 = 2'b01;
   localparam logic [1:0] ERR11 = 2'b11;
   localparam bit         CHK   = 1'b1;
`else
   localparam logic [1:0] ERR01 = 2'b00;
   localparam logic [1:0] ERR11 = 2'b00;
   localparam bit         CHK   = 1'b0;
`endif

   always #5 clk = ~clk;

   batch_ctrl_pp #(.AW(AW), .NBANK(NBANK)) dut (
      .clk(clk), .reset(reset), .run(run),
      .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
      .src_v(src_v), .src_a(src_a), .src_b(src_b), .ss(ss), .ds(ds),
      .s_init(s_init), .s_bank(s_bank), .s_fin(s_fin),
      .dst_v(dst_v), .dst_a(dst_a), .dst_b(dst_b), .dst_valid(dst_valid),
      .dst_last(dst_last), .dst_ready(dst_ready), .busy(busy), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; src_valid = 1'b0; src_last = 1'b0;
      s_fin = 1'b0; dst_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   typedef struct {
      int rep;
      int run, sv, sl, sfin, drdy;
      int srdy, srcv, srca, srcb, sinit, sbank, dstv, dsta, dstb, dval, dlast, busy;
   } vec_t;

   function automatic vec_t mk(input int rep, run_, sv, sl, sfin, drdy,
                               srdy, srcv, srca, srcb, sinit, sbank,
                               dstv, dsta, dstb, dval, dlast, busy_);
      vec_t v;
      v.rep = rep; v.run = run_; v.sv = sv; v.sl = sl; v.sfin = sfin; v.drdy = drdy;
      v.srdy = srdy; v.srcv = srcv; v.srca = srca; v.srcb = srcb; v.sinit = sinit;
      v.sbank = sbank; v.dstv = dstv; v.dsta = dsta; v.dstb = dstb; v.dval = dval;
      v.dlast = dlast; v.busy = busy_;
      return v;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      logic [17:0] got, want;
      int ninit, saw1, found, drained_seen;
      int ssi, dsi, nf, ni, nfin, nd, fcnt, iss, hcnt, dv, e0, e1, occ;
      int b_bank, b_addr;
      bit e_srdy, e_sinit, e_dstv, acc;

      // ---------------- reset state ----------------
      ss = AW'(3); ds = AW'(1);
      do_reset();
      @(negedge clk);
      chk("reset_ctl", 32'({src_ready, src_v, src_b, s_init, s_bank, dst_v, dst_b,
                            dst_valid, dst_last, busy, err}), 32'd0);
      chk("reset_addr", 32'({src_a, dst_a}), 32'd0);
      next_cycle();

      // ---------------- table: single sample, then backpressured drain ----------------
      //                 rep run sv sl fin rdy | srdy srcv a  b  init bank | dstv a b val last busy
      tbl.push_back(mk(1, 1,1,0,0,1, 1,1,0,0, 0,0, 0,0,0, 0,0,0));
      tbl.push_back(mk(1, 1,1,0,0,1, 1,1,1,0, 0,0, 0,0,0, 0,0,0));
      tbl.push_back(mk(1, 1,1,0,0,1, 1,1,2,0, 0,0, 0,0,0, 0,0,0));
      tbl.push_back(mk(1, 1,1,1,0,1, 1,1,3,0, 0,0, 0,0,0, 0,0,0));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,1, 1,0, 0,0,0, 0,0,1));
      tbl.push_back(mk(9, 1,0,0,0,1, 1,0,0,1, 0,0, 0,0,0, 0,0,1));
      tbl.push_back(mk(1, 1,0,0,1,1, 1,0,0,1, 0,0, 0,0,0, 0,0,1));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,1, 0,1, 1,0,0, 0,0,1));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,1, 0,1, 1,1,0, 1,0,1));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,1, 0,1, 0,0,0, 1,1,1));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,1, 0,1, 0,0,1, 0,0,0));
      tbl.push_back(mk(1, 1,1,0,0,1, 1,1,0,1, 0,1, 0,0,1, 0,0,0));
      tbl.push_back(mk(1, 1,1,0,0,1, 1,1,1,1, 0,1, 0,0,1, 0,0,0));
      tbl.push_back(mk(1, 1,1,0,0,1, 1,1,2,1, 0,1, 0,0,1, 0,0,0));
      tbl.push_back(mk(1, 1,1,1,0,1, 1,1,3,1, 0,1, 0,0,1, 0,0,0));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,0, 1,1, 0,0,1, 0,0,1));
      tbl.push_back(mk(2, 1,0,0,0,1, 1,0,0,0, 0,1, 0,0,1, 0,0,1));
      tbl.push_back(mk(1, 1,0,0,1,1, 1,0,0,0, 0,1, 0,0,1, 0,0,1));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,0, 0,0, 1,0,1, 0,0,1));
      tbl.push_back(mk(5, 1,0,0,0,0, 1,0,0,0, 0,0, 0,1,1, 1,0,1));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,0, 0,0, 1,1,1, 1,0,1));
      tbl.push_back(mk(2, 1,0,0,0,0, 1,0,0,0, 0,0, 0,0,1, 1,1,1));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,0, 0,0, 0,0,1, 1,1,1));
      tbl.push_back(mk(1, 1,0,0,0,1, 1,0,0,0, 0,0, 0,0,0, 0,0,0));

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].rep; r++) begin
            run = 1'(tbl[i].run); src_valid = 1'(tbl[i].sv); src_last = 1'(tbl[i].sl);
            s_fin = 1'(tbl[i].sfin); dst_ready = 1'(tbl[i].drdy);
            @(negedge clk);
            got  = {src_ready, src_v, src_a[3:0], src_b, s_init, s_bank, dst_v, dst_a[3:0],
                    dst_b, dst_valid, dst_last & dst_valid, busy};
            want = {1'(tbl[i].srdy), 1'(tbl[i].srcv), 4'(tbl[i].srca), 1'(tbl[i].srcb),
                    1'(tbl[i].sinit), 1'(tbl[i].sbank), 1'(tbl[i].dstv), 4'(tbl[i].dsta),
                    1'(tbl[i].dstb), 1'(tbl[i].dval), 1'(tbl[i].dlast), 1'(tbl[i].busy)};
            chk($sformatf("tbl%0d.%0d", i, r), 32'(got), 32'(want));
            next_cycle();
         end
      end

      // ---------------- full ring: 8 back-to-back beats, no s_fin ----------------
      do_reset();
      run = 1'b1; dst_ready = 1'b1; ninit = 0;
      for (int i = 0; i < 8; i++) begin
         src_valid = 1'b1; src_last = (i % 4 == 3);
         @(negedge clk);
         chk("full_rdy", 32'(src_ready), 32'd1);
         chk("full_a", 32'(src_a), 32'(i % 4));
         chk("full_b", 32'(src_b), 32'(i / 4));
         if (s_init) begin
            ninit++;
            chk("full_sbank0", 32'(s_bank), 32'd0);
         end
         next_cycle();
      end
      for (int i = 0; i < 4; i++) begin
         src_valid = 1'b1; src_last = 1'b0;
         @(negedge clk);
         chk("full_blocked", 32'(src_ready), 32'd0);
         chk("full_no_init", 32'(s_init), 32'd0);
         next_cycle();
      end
      chk("full_init_count", 32'(ninit), 32'd1);
      s_fin = 1'b1;
      @(negedge clk);
      chk("full_fin_rdy", 32'(src_ready), 32'd0);
      next_cycle();
      s_fin = 1'b0;
      saw1 = 0; found = 0; drained_seen = 0;
      for (int i = 0; i < 30 && found == 0; i++) begin
         @(negedge clk);
         if (s_init && s_bank == 1'b1) saw1 = 1;
         if (src_v) begin
            found = 1;
            chk("full_accept_after_drain", 32'(drained_seen), 32'd1);
            chk("full_beat9_a", 32'(src_a), 32'd0);
            chk("full_beat9_b", 32'(src_b), 32'd0);
         end
         if (dst_valid && dst_ready && dst_last) drained_seen = 1;
         next_cycle();
      end
      chk("full_beat9_accepted", 32'(found), 32'd1);
      chk("full_sinit_bank1", 32'(saw1), 32'd1);
      @(negedge clk);
      chk("full_beat10_a", 32'(src_a), 32'd1);
      next_cycle();

      // ---------------- reset mid-fill ----------------
      do_reset();
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ctl", 32'({src_ready, src_v, src_b, s_init, s_bank, dst_v, dst_b,
                             dst_valid, busy, err}), 32'd0);
      chk("midrst_addr", 32'({src_a, dst_a}), 32'd0);
      next_cycle();
      run = 1'b1; src_valid = 1'b1; src_last = 1'b0;
      @(negedge clk);
      chk("midrst_restart", 32'({src_v, src_b, src_a}), 32'({1'b1, 1'b0, 12'd0}));
      next_cycle();

      // ---------------- error flags ----------------
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         src_valid = 1'b1; src_last = (i == 2);
         next_cycle();
      end
      src_valid = 1'b0; src_last = 1'b0; s_fin = 1'b1;
      @(negedge clk);
      chk("err_frame", 32'(err), 32'(ERR01));
      next_cycle();
      s_fin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("err_sticky", 32'(err), 32'(ERR11));
         chk("err_orphan_ignored", 32'(busy), 32'd0);
         next_cycle();
      end
      do_reset();
      @(negedge clk);
      chk("err_cleared", 32'(err), 32'd0);
      next_cycle();

      // ---------------- randomized run against counter model ----------------
      for (int ph = 0; ph < 3; ph++) begin
         ssi = $urandom_range(4, 0); dsi = $urandom_range(4, 0);
         ss = AW'(ssi); ds = AW'(dsi);
         do_reset();
         nf = 0; ni = 0; nfin = 0; nd = 0; fcnt = 0; iss = 0; hcnt = 0; dv = 0;
         e0 = 0; e1 = 0; b_bank = 0; b_addr = 0;
         for (int c = 0; c < 500; c++) begin
            run       = ($urandom_range(9, 0) != 0);
            src_valid = ($urandom_range(9, 0) < 7);
            src_last  = (fcnt == ssi) ^ ($urandom_range(19, 0) == 0);
            dst_ready = ($urandom_range(9, 0) < 6);
            if (ni > nfin) s_fin = ($urandom_range(3, 0) == 0);
            else           s_fin = ($urandom_range(39, 0) == 0);
            @(negedge clk);
            occ     = nf - nd;
            e_srdy  = run && (occ < NBANK);
            e_sinit = run && (ni == nfin) && (nf > ni);
            e_dstv  = (nfin > nd) && (iss <= dsi) && (dv == 0 || dst_ready);
            acc     = src_valid && e_srdy;
            chk("rnd_src_ready", 32'(src_ready), 32'(e_srdy));
            chk("rnd_src_v", 32'(src_v), 32'(acc));
            chk("rnd_busy", 32'(busy), 32'(occ > 0));
            chk("rnd_s_init", 32'(s_init), 32'(e_sinit));
            chk("rnd_s_bank", 32'(s_bank), 32'(nfin % NBANK));
            chk("rnd_dst_valid", 32'(dst_valid), 32'(dv));
            chk("rnd_dst_v", 32'(dst_v), 32'(e_dstv));
            chk("rnd_err", 32'(err), 32'(CHK ? {e1[0], e0[0]} : 2'b00));
            if (acc) begin
               chk("rnd_src_a", 32'(src_a), 32'(fcnt));
               chk("rnd_src_b", 32'(src_b), 32'(nf % NBANK));
            end
            if (dv != 0 && dst_ready) begin
               chk("rnd_out_bank", 32'(b_bank), 32'(nd % NBANK));
               chk("rnd_out_addr", 32'(b_addr), 32'(hcnt));
               chk("rnd_out_last", 32'(dst_last), 32'(hcnt == dsi));
               if (hcnt == dsi) begin
                  nd++; hcnt = 0; iss = 0;
               end else begin
                  hcnt++;
               end
            end
            if (dst_v) begin
               b_bank = int'(dst_b); b_addr = int'(dst_a);
            end
            if (e_dstv) iss++;
            dv = e_dstv ? 1 : (dst_ready ? 0 : dv);
            if (s_fin) begin
               if (ni > nfin) nfin++;
               else           e1 = 1;
            end
            if (e_sinit) ni++;
            if (acc) begin
               if (src_last != (fcnt == ssi)) e0 = 1;
               if (fcnt == ssi) begin
                  fcnt = 0; nf++;
               end else begin
                  fcnt++;
               end
            end
            next_cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
